// File: rtl/preempt_timer_bank.sv
// Bank of independent countdown/quantum timers with sticky expiry flags,
// merged into one prioritised interrupt request for the control unit.
module preempt_timer_bank #(
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 4,
    parameter int CH_W         = 2,
    parameter int DEF_QUANTUM  = 100,
    parameter int DEF_PERIODIC = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_quantum,
    input  logic                cfg_periodic,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    input  logic                ack,
    input  logic [CH_W-1:0]     ack_ch,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] missed,
    output logic                irq,
    output logic [CH_W-1:0]     irq_ch
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CH_W-1:0] w_irq_ch;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_quantum;
        logic [WIDTH-1:0] r_shadow;
        logic             r_periodic;
        logic [0:0]       r_state;
        logic             r_pending;
        logic             r_missed;
        logic [WIDTH-1:0] w_count_inc;
        logic             w_sel_cfg;
        logic             w_sel_ack;
        logic             w_expire;

        assign w_count_inc = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        assign w_sel_cfg   = cfg_we && (cfg_ch == CH_W'(g));
        assign w_sel_ack   = ack && (ack_ch == CH_W'(g));
        // A zero shadow quantum never matches, so such a channel just wraps.
        assign w_expire    = (r_state == ST_RUN) && !stop[g] && !start[g]
                             && (r_shadow != {WIDTH{1'b0}}) && (w_count_inc == r_shadow);

        // Programmable quantum and mode registers.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_quantum  <= WIDTH'(DEF_QUANTUM);
                r_periodic <= 1'(DEF_PERIODIC);
            end else if (w_sel_cfg) begin
                r_quantum  <= cfg_quantum;
                r_periodic <= cfg_periodic;
            end else begin
                r_quantum  <= r_quantum;
                r_periodic <= r_periodic;
            end
        end

        // Channel FSM, counter, shadow quantum and sticky flags.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_count   <= {WIDTH{1'b0}};
                r_shadow  <= WIDTH'(DEF_QUANTUM);
                r_pending <= 1'b0;
                r_missed  <= 1'b0;
            end else if (stop[g]) begin
                r_state   <= ST_IDLE;
                r_count   <= {WIDTH{1'b0}};
                r_pending <= 1'b0;
                r_missed  <= 1'b0;
            end else if (w_expire) begin
                r_count   <= {WIDTH{1'b0}};
                r_pending <= 1'b1;
                r_missed  <= r_missed | r_pending;
                if (r_periodic) begin
                    r_shadow <= r_quantum;
                end else begin
                    r_state  <= ST_IDLE;
                end
            end else begin
                if (start[g]) begin
                    r_state  <= ST_RUN;
                    r_count  <= {WIDTH{1'b0}};
                    r_shadow <= r_quantum;
                end else if (r_state == ST_RUN) begin
                    r_count  <= w_count_inc;
                end else begin
                    r_count  <= r_count;
                end
                if (w_sel_ack) begin
                    r_pending <= 1'b0;
                    r_missed  <= 1'b0;
                end else begin
                    r_pending <= r_pending;
                    r_missed  <= r_missed;
                end
            end
        end

        assign running[g] = (r_state == ST_RUN);
        assign pending[g] = r_pending;
        assign missed[g]  = r_missed;
    end

    // Lowest-index pending channel wins; descending scan lets it overwrite.
    always_comb begin
        w_irq_ch = {CH_W{1'b0}};
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            w_irq_ch = pending[i] ? CH_W'(i) : w_irq_ch;
        end
    end

    assign irq    = |pending;
    assign irq_ch = w_irq_ch;

endmodule
